// File: rtl/branch_target_buffer_if.sv
`timescale 1ns/1ps
// Fetch-side lookup and resolve-side update bundle for the branch target buffer.
// master: fetch/resolve logic driving lookups, updates and flushes.
// slave:  the BTB, returning prediction results and table readiness.
interface branch_target_buffer_if #(
  parameter int ADDR_W = 32
);
  logic              Flush;
  logic [ADDR_W-1:0] RAddr;
  logic              Hit;
  logic              PredTaken;
  logic [ADDR_W-1:0] PPC;
  logic [1:0]        CB;
  logic              UpdValid;
  logic [ADDR_W-1:0] UpdAddr;
  logic              UpdTaken;
  logic [ADDR_W-1:0] UpdTarget;
  logic              Ready;

  modport master (
    output Flush, RAddr, UpdValid, UpdAddr, UpdTaken, UpdTarget,
    input  Hit, PredTaken, PPC, CB, Ready
  );

  modport slave (
    input  Flush, RAddr, UpdValid, UpdAddr, UpdTaken, UpdTarget,
    output Hit, PredTaken, PPC, CB, Ready
  );
endinterface

// File: rtl/branch_target_buffer.sv
`timescale 1ns/1ps
// Set-associative branch target buffer with 2-bit saturating counters.
// Latency: lookup is combinational; updates become visible the cycle after the write edge.
// Backpressure: none; Ready=0 during the SETS-cycle clear sweep, when updates are dropped and lookups miss.
// Ports: Clk, Rst (sync, active-high); bus (slave) carries Flush, lookup RAddr ->
//   Hit/PredTaken/PPC/CB, update UpdValid/UpdAddr/UpdTaken/UpdTarget, and Ready.
module branch_target_buffer #(
  parameter int ADDR_W = 32,
  parameter int SETS   = 64,
  parameter int WAYS   = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  branch_target_buffer_if.slave bus
);

  localparam int IDX_W = $clog2(SETS);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_q, clr_d;
  logic             ready;

  // Storage has no reset; the clear sweep is what makes valid bits defined.
  logic [SETS-1:0]   valid_q [WAYS];
  logic [ADDR_W-1:0] tag_q   [WAYS][SETS];
  logic [ADDR_W-1:0] tgt_q   [WAYS][SETS];
  logic [1:0]        cnt_q   [WAYS][SETS];
  logic [SETS-1:0]   lru_q;   // per set: index of the least recently used way

  // ---------------- control FSM ----------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    case (state_q)
      CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == IDX_W'(SETS - 1)) state_d = RUN;
      end
      RUN: begin
        if (bus.Flush) begin
          state_d = CLEAR;
          clr_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        clr_d   = '0;
      end
    endcase
  end

  assign ready     = (state_q == RUN);
  assign bus.Ready = ready;

  // ---------------- lookup ----------------
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_hit;
  logic              rd_way;
  logic [ADDR_W-1:0] rd_tgt;
  logic [1:0]        rd_cnt;

  assign rd_idx = bus.RAddr[2 +: IDX_W];

  always_comb begin
    rd_hit = 1'b0;
    rd_way = 1'b0;
    rd_tgt = '0;
    rd_cnt = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][rd_idx] && (tag_q[w][rd_idx] == bus.RAddr)) begin
        rd_hit = 1'b1;
        rd_way = 1'(w);
        rd_tgt = tgt_q[w][rd_idx];
        rd_cnt = cnt_q[w][rd_idx];
      end
    end
  end

  assign bus.Hit       = ready & rd_hit;
  assign bus.PredTaken = bus.Hit & rd_cnt[1];
  assign bus.PPC       = bus.Hit ? rd_tgt : '0;
  assign bus.CB        = bus.Hit ? rd_cnt : 2'b00;

  // ---------------- update ----------------
  logic [IDX_W-1:0] up_idx;
  logic             up_hit;
  logic             up_way;
  logic [1:0]       up_cnt;
  logic             victim;
  logic             wr_way;
  logic             up_we;
  logic [1:0]       new_cnt;

  assign up_idx = bus.UpdAddr[2 +: IDX_W];

  always_comb begin
    up_hit = 1'b0;
    up_way = 1'b0;
    up_cnt = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][up_idx] && (tag_q[w][up_idx] == bus.UpdAddr)) begin
        up_hit = 1'b1;
        up_way = 1'(w);
        up_cnt = cnt_q[w][up_idx];
      end
    end
  end

  // Prefer the lowest invalid way; only when the set is full fall back to LRU.
  always_comb begin
    victim = 1'b0;
    if (WAYS == 2) begin
      if (!valid_q[0][up_idx])      victim = 1'b0;
      else if (!valid_q[1][up_idx]) victim = 1'b1;
      else                          victim = lru_q[up_idx];
    end
  end

  // Not-taken misses leave the table untouched, so they are not writes at all.
  assign up_we  = ready & ~Rst & bus.UpdValid & (up_hit | bus.UpdTaken);
  assign wr_way = up_hit ? up_way : victim;

  always_comb begin
    new_cnt = 2'b10;
    if (up_hit) begin
      if (bus.UpdTaken) new_cnt = (up_cnt == 2'b11) ? 2'b11 : up_cnt + 2'b01;
      else              new_cnt = (up_cnt == 2'b00) ? 2'b00 : up_cnt - 2'b01;
    end
  end

  // ---------------- storage ----------------
  always_ff @(posedge Clk) begin
    if (state_q == CLEAR) begin
      for (int w = 0; w < WAYS; w++) valid_q[w][clr_q] <= 1'b0;
      lru_q[clr_q] <= 1'b0;
    end else begin
      if (up_we) begin
        for (int w = 0; w < WAYS; w++) begin
          if (wr_way == 1'(w)) begin
            valid_q[w][up_idx] <= 1'b1;
            tag_q[w][up_idx]   <= bus.UpdAddr;
            cnt_q[w][up_idx]   <= new_cnt;
            if (bus.UpdTaken) tgt_q[w][up_idx] <= bus.UpdTarget;
          end
        end
        if (WAYS == 2) lru_q[up_idx] <= ~wr_way;
      end
      // A lookup hit refreshes recency unless a write to the same set wins this cycle.
      if ((WAYS == 2) && bus.Hit && !(up_we && (up_idx == rd_idx))) begin
        lru_q[rd_idx] <= ~rd_way;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
`timescale 1ns/1ps
module tb_branch_target_buffer;

  localparam logic [31:0] IDLE = 32'h0000_0004;   // set 1, never written

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  branch_target_buffer_if #(.ADDR_W(32)) bif();

  branch_target_buffer #(.ADDR_W(32), .SETS(64), .WAYS(2)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bif.slave)
  );

  typedef struct packed {
    logic        rdy;
    logic        hit;
    logic        pt;
    logic [31:0] ppc;
    logic [1:0]  cb;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;
  logic  look_vld = 1'b0;

  // Monitor: every presented lookup is compared against the oldest expectation.
  always @(negedge Clk) begin
    exp_t  act;
    exp_t  e;
    string nm;
    if (look_vld) begin
      act.rdy = bif.Ready;
      act.hit = bif.Hit;
      act.pt  = bif.PredTaken;
      act.ppc = bif.PPC;
      act.cb  = bif.CB;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_lookup: got rdy=%0b hit=%0b with no expectation queued", act.rdy, act.hit);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL %s: got rdy=%0b hit=%0b pt=%0b ppc=%h cb=%0d, want rdy=%0b hit=%0b pt=%0b ppc=%h cb=%0d",
                   nm, act.rdy, act.hit, act.pt, act.ppc, act.cb, e.rdy, e.hit, e.pt, e.ppc, e.cb);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    look_vld     = 1'b0;
    bif.RAddr    = IDLE;
    bif.UpdValid = 1'b0;
    bif.Flush    = 1'b0;
  endtask

  task automatic look(input string nm, input logic [31:0] a, input logic r, input logic h,
                      input logic pt, input logic [31:0] ppc, input logic [1:0] cb);
    exp_t e;
    e.rdy = r; e.hit = h; e.pt = pt; e.ppc = ppc; e.cb = cb;
    bif.RAddr = a;
    look_vld  = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic upd(input logic [31:0] a, input logic tk, input logic [31:0] tg);
    bif.UpdValid  = 1'b1;
    bif.UpdAddr   = a;
    bif.UpdTaken  = tk;
    bif.UpdTarget = tg;
  endtask

  task automatic lk(input string nm, input logic [31:0] a, input logic h,
                    input logic pt, input logic [31:0] ppc, input logic [1:0] cb);
    look(nm, a, 1'b1, h, pt, ppc, cb);
    step();
  endtask

  task automatic miss(input string nm, input logic [31:0] a);
    lk(nm, a, 1'b0, 1'b0, 32'h0, 2'b00);
  endtask

  task automatic up(input logic [31:0] a, input logic tk, input logic [31:0] tg);
    upd(a, tk, tg);
    step();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bif.Ready && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bif.Flush = 1'b0; bif.RAddr = IDLE; bif.UpdValid = 1'b0;
    bif.UpdAddr = '0; bif.UpdTaken = 1'b0; bif.UpdTarget = '0;

    // Reset: one edge with Rst, then a 64-cycle sweep before Ready.
    step();
    Rst = 1'b0;
    chk("ready_after_rst", int'(bif.Ready), 0);
    look("rst_sweep_lookup", 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
    step();
    wait_ready(n);
    chk("rst_sweep_len", n + 1, 64);
    miss("empty_0x100", 32'h100);
    miss("empty_0x0", 32'h0);

    // Allocation, counter moves, saturation.
    up(32'h100, 1'b1, 32'h400);
    lk("alloc_0x100", 32'h100, 1'b1, 1'b1, 32'h400, 2'b10);
    up(32'h100, 1'b0, 32'h0);
    lk("nt_0x100", 32'h100, 1'b1, 1'b0, 32'h400, 2'b01);
    up(32'h100, 1'b1, 32'h400);
    up(32'h100, 1'b1, 32'h400);
    up(32'h100, 1'b1, 32'h480);
    lk("sat_hi", 32'h100, 1'b1, 1'b1, 32'h480, 2'b11);
    repeat (4) up(32'h100, 1'b0, 32'h0);
    lk("sat_lo", 32'h100, 1'b1, 1'b0, 32'h480, 2'b00);

    // Flush; an update mid-sweep must be dropped.
    bif.Flush = 1'b1;
    step();
    repeat (4) step();
    up(32'h700, 1'b1, 32'h7000);
    wait_ready(n);
    chk("flush_sweep_len", n + 5, 64);
    miss("flushed_0x100", 32'h100);
    miss("dropped_0x700", 32'h700);

    // LRU replacement in set 0.
    up(32'h100, 1'b1, 32'h1000);
    up(32'h200, 1'b1, 32'h2000);
    lk("lru_touch_0x100", 32'h100, 1'b1, 1'b1, 32'h1000, 2'b10);
    up(32'h300, 1'b1, 32'h3000);
    miss("evicted_0x200", 32'h200);
    lk("kept_0x100", 32'h100, 1'b1, 1'b1, 32'h1000, 2'b10);
    lk("alloc_0x300", 32'h300, 1'b1, 1'b1, 32'h3000, 2'b10);

    // Not-taken miss does not allocate.
    up(32'h500, 1'b0, 32'h5555);
    miss("nt_miss_0x500", 32'h500);

    // Same-cycle lookup sees pre-update contents.
    upd(32'h600, 1'b1, 32'h6000);
    look("no_bypass_0x600", 32'h600, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00);
    step();
    lk("alloc_0x600", 32'h600, 1'b1, 1'b1, 32'h6000, 2'b10);
    miss("evicted_0x100", 32'h100);
    lk("kept_0x300", 32'h300, 1'b1, 1'b1, 32'h3000, 2'b10);

    // Update beats a same-set lookup hit for recency: 0x300 stays LRU.
    upd(32'h600, 1'b1, 32'h6000);
    look("prec_look_0x300", 32'h300, 1'b1, 1'b1, 1'b1, 32'h3000, 2'b10);
    step();
    up(32'h900, 1'b1, 32'h9000);
    miss("prec_evicted_0x300", 32'h300);
    lk("prec_kept_0x600", 32'h600, 1'b1, 1'b1, 32'h6000, 2'b11);
    lk("alloc_0x900", 32'h900, 1'b1, 1'b1, 32'h9000, 2'b10);

    // Last set.
    up(32'hFC, 1'b1, 32'hF00);
    lk("alloc_set63", 32'hFC, 1'b1, 1'b1, 32'hF00, 2'b10);

    // Flush, then Rst at sweep cycle 10 restarts the sweep.
    bif.Flush = 1'b1;
    step();
    repeat (4) step();
    look("sweep_gated_set63", 32'hFC, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
    step();
    repeat (4) step();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    wait_ready(n);
    chk("rst_restart_len", n, 64);
    miss("post_rst_0x600", 32'h600);
    miss("post_rst_0x900", 32'h900);
    miss("post_rst_set63", 32'hFC);

    step();
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, instruction/target address width.
REQ-002 SHALL have parameter SETS, default 64, number of sets; power of 2, 2..1024.
REQ-003 SHALL have parameter WAYS, default 2, associativity; legal values 1 or 2.
REQ-004 SHALL have port Clk  input  1  clock, all state changes on rising edge.
REQ-005 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port Flush  input  1  single-cycle request to invalidate all entries.
REQ-007 SHALL have port RAddr  input  ADDR_W  fetch PC looked up.
REQ-008 SHALL have port Hit  output  1  RAddr matches a valid entry.
REQ-009 SHALL have port PredTaken  output  1  Hit AND entry counter bit 1; 1 = use PPC, 0 = use PC+4.
REQ-010 SHALL have port PPC  output  ADDR_W  predicted target of the matching entry.
REQ-011 SHALL have port CB  output  2  saturating counter of the matching entry.
REQ-012 SHALL have port UpdValid  input  1  resolved-branch update strobe.
REQ-013 SHALL have port UpdAddr  input  ADDR_W  address of the resolved branch.
REQ-014 SHALL have port UpdTaken  input  1  actual branch outcome.
REQ-015 SHALL have port UpdTarget  input  ADDR_W  actual branch target.
REQ-016 SHALL have port Ready  output  1  1 = table usable; 0 = clear sweep in progress.

Function
REQ-017 SHALL derive set index = addr[2 +: log2(SETS)]; tag = full ADDR_W address; each way stores {valid, tag, target, 2-bit counter}; one LRU bit per set when WAYS=2.
REQ-018 SHALL perform lookup combinationally from RAddr in the same cycle; at most one way matches; Hit/PPC/CB come from the matching way.
REQ-019 SHALL drive Hit=0, PredTaken=0, PPC=0, CB=0 whenever there is no match or Ready=0.
REQ-020 SHALL, on UpdValid with an UpdAddr hit, set counter to min(cnt+1,3) if UpdTaken else max(cnt-1,0), and write target=UpdTarget only when UpdTaken=1.
REQ-021 SHALL, on UpdValid with a miss and UpdTaken=1, allocate: victim = lowest-numbered invalid way, otherwise the LRU way; write valid=1, tag=UpdAddr, target=UpdTarget, counter=2'b10.
REQ-022 SHALL not allocate on a miss with UpdTaken=0; table unchanged.
REQ-023 SHALL, when WAYS=2, mark the written/updated way MRU on every update, and the hit way MRU on a lookup hit.
REQ-024 SHALL give the update precedence when a lookup hit and an update target the same set in the same cycle.
REQ-025 SHALL make writes visible from the next cycle; same-cycle lookup of UpdAddr returns pre-update contents (no bypass).
REQ-026 SHALL implement FSM states CLEAR and RUN; CLEAR invalidates one set per cycle (all ways, LRU=0) using a log2(SETS)-bit counter from 0 to SETS-1, then enters RUN.
REQ-027 SHALL enter CLEAR with counter=0 on Flush in RUN; Flush during CLEAR is ignored.
REQ-028 SHALL drive Ready=1 only in RUN; UpdValid is ignored while Ready=0.
REQ-029 SHALL take exactly SETS cycles in CLEAR; Ready rises on the edge after set SETS-1 is cleared.
REQ-030 SHALL support WAYS=1 as direct-mapped, with no LRU state and victim always way 0.

Reset
REQ-031 SHALL, on Rst=1 at a rising edge, enter CLEAR with counter=0, regardless of state, including mid-sweep (sweep restarts at 0).
REQ-032 SHALL hold Ready=0 and Hit=PredTaken=0, PPC=0, CB=0 from the first edge with Rst=1 until the sweep completes after Rst deasserts.
REQ-033 SHALL not require storage arrays to have a defined power-up value; only the sweep guarantees valid=0.

Verification
REQ-034 SHALL pass the following check: Rst for 1 cycle -> Ready=0 for exactly 64 cycles, then Ready=1; lookup of any address gives Hit=0.
REQ-035 SHALL pass the following check: update 0x100 taken to 0x400 -> next cycle RAddr=0x100 gives Hit=1, CB=2'b10, PredTaken=1, PPC=0x400; then not-taken update -> CB=2'b01, PredTaken=0.
REQ-036 SHALL pass the following check: 3 taken updates on 0x100 -> CB saturates at 2'b11; 4 not-taken updates -> CB=2'b00, Hit remains 1.
REQ-037 SHALL pass the following check: taken allocation of 0x100, then 0x200, then lookup hit 0x100, then allocation of 0x300 (all set 0) -> 0x200 evicted; 0x100 and 0x300 hit.
REQ-038 SHALL pass the following check: not-taken update on a miss address 0x500 -> lookup 0x500 gives Hit=0.
REQ-039 SHALL pass the following check: Flush with entries valid, then Rst asserted at sweep cycle 10 -> sweep restarts; Ready=1 exactly 64 cycles after Rst deasserts; all lookups miss.
